// File: rtl/bus_interconnect_mslave_if.sv
// Bus bundle between the processor-side requester, the interconnect and its
// slave ports. Signal suffixes are from the interconnect's point of view.
// The master modport is the environment view: the processor plus slave set
// that drives the interconnect's inputs. The slave modport is the
// interconnect itself.
interface bus_interconnect_mslave_if #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int N_SLAVES = 3
);
    // Processor side
    logic                         proc_rd_en_i;
    logic                         proc_wr_en_i;
    logic [ADDR_W-1:0]            proc_addr_i;
    logic [DATA_W-1:0]            proc_data_i;
    logic [DATA_W-1:0]            proc_data_o;
    logic                         proc_ack_o;
    logic                         proc_err_o;

    // Slave side
    logic [N_SLAVES-1:0]          slv_rd_en_o;
    logic [N_SLAVES-1:0]          slv_wr_en_o;
    logic [ADDR_W-1:0]            slv_addr_o;
    logic [DATA_W-1:0]            slv_data_o;
    logic [N_SLAVES*DATA_W-1:0]   slv_data_i;
    logic [N_SLAVES-1:0]          slv_ack_i;

    modport master (
        output proc_rd_en_i, proc_wr_en_i, proc_addr_i, proc_data_i,
        output slv_data_i, slv_ack_i,
        input  proc_data_o, proc_ack_o, proc_err_o,
        input  slv_rd_en_o, slv_wr_en_o, slv_addr_o, slv_data_o
    );

    modport slave (
        input  proc_rd_en_i, proc_wr_en_i, proc_addr_i, proc_data_i,
        input  slv_data_i, slv_ack_i,
        output proc_data_o, proc_ack_o, proc_err_o,
        output slv_rd_en_o, slv_wr_en_o, slv_addr_o, slv_data_o
    );
endinterface

// File: rtl/bus_interconnect_mslave.sv
// Single-master, N-slave registered bus interconnect with one outstanding
// transaction. The top SEL_W address bits pick the slave; decode errors,
// simultaneous read/write requests and slave timeouts all complete with an
// error response so the processor never stalls indefinitely.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for a request; only state in which requests are sampled
// ACCESS | strobe held to the selected slave, timeout counter running
// RESP   | one-cycle proc_ack_o with read data / error flag
module bus_interconnect_mslave #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int SEL_W    = 2,
    parameter int N_SLAVES = 3,
    parameter int TIMEOUT  = 16
) (
    input logic                      clk,
    input logic                      rst,
    bus_interconnect_mslave_if.slave bus
);

    // Counter only has to reach TIMEOUT-1.
    localparam int                CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [SEL_W:0]    N_SLV     = (SEL_W + 1)'(N_SLAVES);
    localparam logic [ADDR_W-1:0] ADDR_MASK = {{SEL_W{1'b0}}, {(ADDR_W - SEL_W){1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SEL_W-1:0]    idx_q, idx_d;
    logic                is_rd_q, is_rd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [N_SLAVES-1:0] rd_stb_q, rd_stb_d;
    logic [N_SLAVES-1:0] wr_stb_q, wr_stb_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [SEL_W-1:0]    req_idx;
    logic [N_SLAVES-1:0] req_onehot;
    logic                req_any;
    logic                req_bad;
    logic                sel_ack;
    logic [DATA_W-1:0]   sel_data;

    // Decode the incoming request and mux the latched slave's ack/read data.
    // A loop compare avoids indexing past N_SLAVES when SEL_W is wider.
    always_comb begin
        req_idx    = bus.proc_addr_i[ADDR_W-1 -: SEL_W];
        req_onehot = '0;
        sel_ack    = 1'b0;
        sel_data   = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (req_idx == SEL_W'(k)) begin
                req_onehot[k] = 1'b1;
            end
            if (idx_q == SEL_W'(k)) begin
                sel_ack  = bus.slv_ack_i[k];
                sel_data = bus.slv_data_i[k*DATA_W +: DATA_W];
            end
        end
        req_any = bus.proc_rd_en_i | bus.proc_wr_en_i;
        req_bad = (bus.proc_rd_en_i & bus.proc_wr_en_i) | ({1'b0, req_idx} >= N_SLV);
    end

    // Next-state and next-output computation for the transaction FSM.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        is_rd_d  = is_rd_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rd_stb_d = rd_stb_q;
        wr_stb_d = wr_stb_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        rdata_d  = '0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d    = '0;
                rd_stb_d = '0;
                wr_stb_d = '0;
                // Latch only on a real request so slv_addr_o/slv_data_o keep
                // their last value while the bus is quiet.
                if (req_any) begin
                    idx_d   = req_idx;
                    is_rd_d = bus.proc_rd_en_i;
                    addr_d  = bus.proc_addr_i & ADDR_MASK;
                    wdata_d = bus.proc_data_i;
                    if (req_bad) begin
                        state_d = S_RESP;
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d  = S_ACCESS;
                        rd_stb_d = bus.proc_rd_en_i ? req_onehot : '0;
                        wr_stb_d = bus.proc_wr_en_i ? req_onehot : '0;
                    end
                end
            end

            S_ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                // Ack is checked first so an ack on the last allowed cycle
                // still completes without error.
                if (sel_ack) begin
                    state_d  = S_RESP;
                    rd_stb_d = '0;
                    wr_stb_d = '0;
                    ack_d    = 1'b1;
                    rdata_d  = is_rd_q ? sel_data : '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = S_RESP;
                    rd_stb_d = '0;
                    wr_stb_d = '0;
                    ack_d    = 1'b1;
                    err_d    = 1'b1;
                end
            end

            S_RESP: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end

            default: begin
                state_d  = S_IDLE;
                cnt_d    = '0;
                rd_stb_d = '0;
                wr_stb_d = '0;
            end
        endcase
    end

    // State and registered outputs; async reset clears strobes immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            is_rd_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_stb_q <= '0;
            wr_stb_q <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            is_rd_q  <= is_rd_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_stb_q <= rd_stb_d;
            wr_stb_q <= wr_stb_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.proc_data_o = rdata_q;
    assign bus.proc_ack_o  = ack_q;
    assign bus.proc_err_o  = err_q;
    assign bus.slv_rd_en_o = rd_stb_q;
    assign bus.slv_wr_en_o = wr_stb_q;
    assign bus.slv_addr_o  = addr_q;
    assign bus.slv_data_o  = wdata_q;

endmodule

// File: tb/tb_bus_interconnect_mslave.sv
// Bench for bus_interconnect_mslave: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_bus_interconnect_mslave;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 32;
    localparam int SEL_W    = 2;
    localparam int N_SLAVES = 3;
    localparam int TIMEOUT  = 16;
    localparam int BUDGET   = 60;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bus_interconnect_mslave_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_SLAVES(N_SLAVES)) bus_if ();

    bus_interconnect_mslave #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SEL_W(SEL_W),
        .N_SLAVES(N_SLAVES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int                  ack_cyc;
        int                  stb_cyc;
        logic [N_SLAVES-1:0] rd_mask;
        logic [N_SLAVES-1:0] wr_mask;
        logic                multi_hot;
        logic                unstable;
        logic                leak;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   wdata;
        logic [DATA_W-1:0]   data;
        logic                err;
    } obs_t;

    typedef struct {
        int                  ack_cyc;
        int                  stb_cyc;
        logic [N_SLAVES-1:0] rd_mask;
        logic [N_SLAVES-1:0] wr_mask;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   data;
        logic                err;
    } exp_t;

    // Transaction-level model: what the requester should see, from the
    // decode/latency rules alone.
    function automatic exp_t model(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                                   input int ack_at, input logic [DATA_W-1:0] rdata);
        exp_t e;
        int   idx;
        bit   served;
        idx       = int'(addr >> (ADDR_W - SEL_W));
        e.addr    = addr % (64'd1 << (ADDR_W - SEL_W));
        e.rd_mask = '0;
        e.wr_mask = '0;
        if ((rd && wr) || idx >= N_SLAVES) begin
            e.stb_cyc = 0;
            e.ack_cyc = 1;
            e.err     = 1'b1;
            e.data    = '0;
        end else begin
            served    = (ack_at >= 1) && (ack_at <= TIMEOUT);
            e.stb_cyc = served ? ack_at : TIMEOUT;
            e.ack_cyc = e.stb_cyc + 1;
            e.err     = !served;
            e.data    = (served && rd) ? rdata : '0;
            if (rd) e.rd_mask = N_SLAVES'(1 << idx);
            else    e.wr_mask = N_SLAVES'(1 << idx);
        end
        return e;
    endfunction

    // Issue one request and act as the slave set until proc_ack_o (bounded).
    // ack_at: strobe cycle in which the selected slave acks (0 = never).
    task automatic do_txn(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, input int ack_at,
                          input logic [DATA_W-1:0] rdata, input bit hold, input bit stray,
                          output obs_t o);
        int sidx;
        int nstb;
        logic [N_SLAVES-1:0] stb;
        o.ack_cyc = -1; o.stb_cyc = 0; o.rd_mask = '0; o.wr_mask = '0;
        o.multi_hot = 1'b0; o.unstable = 1'b0; o.leak = 1'b0;
        o.addr = '0; o.wdata = '0; o.data = '0; o.err = 1'b0;
        sidx = int'(addr[ADDR_W-1 -: SEL_W]);
        nstb = 0;
        @(negedge clk);
        bus_if.proc_rd_en_i = rd;
        bus_if.proc_wr_en_i = wr;
        bus_if.proc_addr_i  = addr;
        bus_if.proc_data_i  = wdata;
        @(posedge clk);
        #1;
        if (!hold) begin
            bus_if.proc_rd_en_i = 1'b0;
            bus_if.proc_wr_en_i = 1'b0;
        end
        for (int c = 1; c <= BUDGET; c++) begin
            @(negedge clk);
            bus_if.slv_ack_i = '0;
            for (int k = 0; k < N_SLAVES; k++) bus_if.slv_data_i[k*DATA_W +: DATA_W] = $urandom;
            stb = bus_if.slv_rd_en_o | bus_if.slv_wr_en_o;
            if (stb != '0) begin
                nstb++;
                if ($countones(stb) != 1) o.multi_hot = 1'b1;
                if (nstb == 1) begin
                    o.addr    = bus_if.slv_addr_o;
                    o.wdata   = bus_if.slv_data_o;
                    o.rd_mask = bus_if.slv_rd_en_o;
                    o.wr_mask = bus_if.slv_wr_en_o;
                end else if (o.addr !== bus_if.slv_addr_o || o.wdata !== bus_if.slv_data_o ||
                             o.rd_mask !== bus_if.slv_rd_en_o || o.wr_mask !== bus_if.slv_wr_en_o) begin
                    o.unstable = 1'b1;
                end
                if (stray) begin
                    for (int k = 0; k < N_SLAVES; k++)
                        if (k != sidx) bus_if.slv_ack_i[k] = 1'($urandom_range(0, 1));
                end
                if (ack_at == nstb && sidx < N_SLAVES) begin
                    bus_if.slv_ack_i[sidx] = 1'b1;
                    bus_if.slv_data_i[sidx*DATA_W +: DATA_W] = rdata;
                end
            end
            if (bus_if.proc_ack_o) begin
                o.ack_cyc = c;
                o.data    = bus_if.proc_data_o;
                o.err     = bus_if.proc_err_o;
                break;
            end else if (bus_if.proc_data_o !== '0 || bus_if.proc_err_o !== 1'b0) begin
                o.leak = 1'b1;
            end
        end
        o.stb_cyc = nstb;
        bus_if.slv_ack_i = '0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (bus_if.proc_ack_o !== 1'b0 || bus_if.proc_err_o !== 1'b0 || bus_if.proc_data_o !== '0)
            $display("FAIL reset_proc_out: got ack=%b err=%b data=%h expected all 0",
                     bus_if.proc_ack_o, bus_if.proc_err_o, bus_if.proc_data_o);
        else n_pass++;
        n_checks++;
        if (bus_if.slv_rd_en_o !== '0 || bus_if.slv_wr_en_o !== '0 ||
            bus_if.slv_addr_o !== '0 || bus_if.slv_data_o !== '0)
            $display("FAIL reset_slv_out: got rd=%b wr=%b addr=%h data=%h expected all 0",
                     bus_if.slv_rd_en_o, bus_if.slv_wr_en_o, bus_if.slv_addr_o, bus_if.slv_data_o);
        else n_pass++;
    endtask

    task automatic test_zero_wait_read();
        obs_t o;
        do_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1, 32'hDEAD_BEEF, 1'b0, 1'b0, o);
        n_checks++;
        if (o.ack_cyc !== 2) $display("FAIL zw_ack_cycle: got %0d expected 2", o.ack_cyc);
        else n_pass++;
        n_checks++;
        if (o.rd_mask !== 3'b001 || o.wr_mask !== 3'b000 || o.stb_cyc !== 1)
            $display("FAIL zw_strobe: got rd=%b wr=%b cycles=%0d expected rd=001 wr=000 cycles=1",
                     o.rd_mask, o.wr_mask, o.stb_cyc);
        else n_pass++;
        n_checks++;
        if (o.addr !== 32'h0000_0010) $display("FAIL zw_addr: got %h expected 00000010", o.addr);
        else n_pass++;
        n_checks++;
        if (o.data !== 32'hDEAD_BEEF || o.err !== 1'b0)
            $display("FAIL zw_resp: got data=%h err=%b expected deadbeef err=0", o.data, o.err);
        else n_pass++;
    endtask

    task automatic test_wait_write();
        obs_t o;
        do_txn(1'b0, 1'b1, 32'h4000_0004, 32'h1234_5678, 3, 32'hFFFF_FFFF, 1'b0, 1'b0, o);
        n_checks++;
        if (o.ack_cyc !== 4) $display("FAIL ww_ack_cycle: got %0d expected 4", o.ack_cyc);
        else n_pass++;
        n_checks++;
        if (o.wr_mask !== 3'b010 || o.rd_mask !== 3'b000 || o.stb_cyc !== 3 || o.unstable)
            $display("FAIL ww_strobe: got wr=%b rd=%b cycles=%0d unstable=%b expected wr=010 rd=000 cycles=3 unstable=0",
                     o.wr_mask, o.rd_mask, o.stb_cyc, o.unstable);
        else n_pass++;
        n_checks++;
        if (o.addr !== 32'h0000_0004 || o.wdata !== 32'h1234_5678)
            $display("FAIL ww_addr_data: got addr=%h data=%h expected 00000004 12345678", o.addr, o.wdata);
        else n_pass++;
        n_checks++;
        if (o.data !== 32'h0 || o.err !== 1'b0)
            $display("FAIL ww_resp: got data=%h err=%b expected 0 err=0", o.data, o.err);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus_if.slv_addr_o !== 32'h0000_0004 || bus_if.slv_data_o !== 32'h1234_5678)
            $display("FAIL ww_hold_idle: got addr=%h data=%h expected 00000004 12345678",
                     bus_if.slv_addr_o, bus_if.slv_data_o);
        else n_pass++;
    endtask

    task automatic test_decode_error();
        obs_t o;
        do_txn(1'b1, 1'b0, 32'hC000_0000, 32'h0, 1, 32'hAAAA_AAAA, 1'b0, 1'b0, o);
        n_checks++;
        if (o.ack_cyc !== 1 || o.err !== 1'b1 || o.data !== '0)
            $display("FAIL dec_resp: got cycle=%0d err=%b data=%h expected 1 1 0", o.ack_cyc, o.err, o.data);
        else n_pass++;
        n_checks++;
        if (o.stb_cyc !== 0) $display("FAIL dec_no_strobe: got %0d strobe cycles expected 0", o.stb_cyc);
        else n_pass++;
    endtask

    task automatic test_timeout();
        obs_t o;
        do_txn(1'b1, 1'b0, 32'h8000_0020, 32'h0, 0, 32'h5555_5555, 1'b0, 1'b1, o);
        n_checks++;
        if (o.stb_cyc !== TIMEOUT || o.rd_mask !== 3'b100)
            $display("FAIL to_strobe: got cycles=%0d rd=%b expected %0d rd=100", o.stb_cyc, o.rd_mask, TIMEOUT);
        else n_pass++;
        n_checks++;
        if (o.ack_cyc !== TIMEOUT + 1 || o.err !== 1'b1 || o.data !== '0)
            $display("FAIL to_resp: got cycle=%0d err=%b data=%h expected %0d 1 0",
                     o.ack_cyc, o.err, o.data, TIMEOUT + 1);
        else n_pass++;
        // Ack on the final allowed cycle beats the timeout.
        do_txn(1'b1, 1'b0, 32'h8000_0024, 32'h0, TIMEOUT, 32'h0BAD_F00D, 1'b0, 1'b1, o);
        n_checks++;
        if (o.ack_cyc !== TIMEOUT + 1 || o.err !== 1'b0 || o.data !== 32'h0BAD_F00D)
            $display("FAIL to_edge_ack: got cycle=%0d err=%b data=%h expected %0d 0 0badf00d",
                     o.ack_cyc, o.err, o.data, TIMEOUT + 1);
        else n_pass++;
    endtask

    task automatic test_illegal_back_to_back();
        obs_t o;
        do_txn(1'b1, 1'b1, 32'h0000_0008, 32'h0, 1, 32'h1111_1111, 1'b0, 1'b0, o);
        n_checks++;
        if (o.ack_cyc !== 1 || o.err !== 1'b1 || o.stb_cyc !== 0)
            $display("FAIL ill_resp: got cycle=%0d err=%b strobes=%0d expected 1 1 0", o.ack_cyc, o.err, o.stb_cyc);
        else n_pass++;
        // Read held high through its ack, then a new read sampled in the
        // very next IDLE cycle.
        do_txn(1'b1, 1'b0, 32'h4000_0100, 32'h0, 2, 32'h2222_2222, 1'b1, 1'b0, o);
        n_checks++;
        if (o.ack_cyc !== 3 || o.data !== 32'h2222_2222 || o.err !== 1'b0)
            $display("FAIL b2b_first: got cycle=%0d data=%h err=%b expected 3 22222222 0", o.ack_cyc, o.data, o.err);
        else n_pass++;
        do_txn(1'b1, 1'b0, 32'h4000_0100, 32'h0, 1, 32'h3333_3333, 1'b0, 1'b0, o);
        n_checks++;
        if (o.ack_cyc !== 2 || o.data !== 32'h3333_3333 || o.rd_mask !== 3'b010)
            $display("FAIL b2b_second: got cycle=%0d data=%h rd=%b expected 2 33333333 010",
                     o.ack_cyc, o.data, o.rd_mask);
        else n_pass++;
    endtask

    task automatic test_reset_mid_access();
        obs_t o;
        bit   acked;
        @(negedge clk);
        bus_if.proc_rd_en_i = 1'b1;
        bus_if.proc_addr_i  = 32'h0000_0040;
        @(posedge clk);
        #1 bus_if.proc_rd_en_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (bus_if.slv_rd_en_o !== 3'b001)
            $display("FAIL rst_pre_strobe: got %b expected 001", bus_if.slv_rd_en_o);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus_if.slv_rd_en_o !== '0 || bus_if.slv_wr_en_o !== '0 || bus_if.proc_ack_o !== 1'b0 ||
            bus_if.proc_err_o !== 1'b0 || bus_if.proc_data_o !== '0 || bus_if.slv_addr_o !== '0)
            $display("FAIL rst_async_clear: got rd=%b wr=%b ack=%b addr=%h expected all 0",
                     bus_if.slv_rd_en_o, bus_if.slv_wr_en_o, bus_if.proc_ack_o, bus_if.slv_addr_o);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        acked = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus_if.proc_ack_o || bus_if.slv_rd_en_o != '0) acked = 1'b1;
        end
        n_checks++;
        if (acked) $display("FAIL rst_no_ack: got activity=1 expected 0");
        else n_pass++;
        do_txn(1'b1, 1'b0, 32'h0000_0044, 32'h0, 1, 32'hCAFE_0001, 1'b0, 1'b0, o);
        n_checks++;
        if (o.ack_cyc !== 2 || o.data !== 32'hCAFE_0001 || o.err !== 1'b0)
            $display("FAIL rst_recover: got cycle=%0d data=%h err=%b expected 2 cafe0001 0", o.ack_cyc, o.data, o.err);
        else n_pass++;
    endtask

    task automatic test_random();
        obs_t o;
        exp_t e;
        logic rd, wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata, rdata;
        int op, ack_at;
        for (int t = 0; t < 24; t++) begin
            op     = $urandom_range(0, 7);
            rd     = (op == 0) || (op >= 1 && op <= 4);
            wr     = (op == 0) || (op >= 5);
            addr   = $urandom;
            wdata  = $urandom;
            rdata  = $urandom;
            ack_at = $urandom_range(0, TIMEOUT + 2);
            e = model(rd, wr, addr, ack_at, rdata);
            do_txn(rd, wr, addr, wdata, ack_at, rdata, 1'b0, 1'($urandom_range(0, 1)), o);
            n_checks++;
            if (o.ack_cyc !== e.ack_cyc || o.err !== e.err || o.data !== e.data)
                $display("FAIL rnd_resp[%0d]: got cycle=%0d err=%b data=%h expected %0d %b %h",
                         t, o.ack_cyc, o.err, o.data, e.ack_cyc, e.err, e.data);
            else n_pass++;
            n_checks++;
            if (o.stb_cyc !== e.stb_cyc || o.rd_mask !== e.rd_mask || o.wr_mask !== e.wr_mask ||
                o.multi_hot || o.unstable || o.leak)
                $display("FAIL rnd_strobe[%0d]: got cycles=%0d rd=%b wr=%b mh=%b unst=%b leak=%b expected %0d %b %b 0 0 0",
                         t, o.stb_cyc, o.rd_mask, o.wr_mask, o.multi_hot, o.unstable, o.leak,
                         e.stb_cyc, e.rd_mask, e.wr_mask);
            else n_pass++;
            if (e.stb_cyc > 0) begin
                n_checks++;
                if (o.addr !== e.addr || (wr && o.wdata !== wdata))
                    $display("FAIL rnd_latch[%0d]: got addr=%h data=%h expected %h %h",
                             t, o.addr, o.wdata, e.addr, wdata);
                else n_pass++;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus_if.proc_rd_en_i = 1'b0;
        bus_if.proc_wr_en_i = 1'b0;
        bus_if.proc_addr_i  = '0;
        bus_if.proc_data_i  = '0;
        bus_if.slv_data_i   = '0;
        bus_if.slv_ack_i    = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_zero_wait_read();
        test_wait_write();
        test_decode_error();
        test_timeout();
        test_illegal_back_to_back();
        test_reset_mid_access();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
